wb_cmd_host: RTL and testbench

Single-outstanding WISHBONE classic-cycle initiator that turns a valid/ready command stream into bus transactions and returns a valid/ready response. It is the host-side counterpart to the board intercon and plugs into one of its master ports (22-bit address, 32-bit data). Serial or packet front ends use it in place of hand-rolled bus-cycle logic. It also provides bounded retry and an optional timeout, so a missing target cannot hang the front end.

---
 rtl/wb_cmd_host.sv | 200 ++++++++++++++++++++
 tb/tb_wb_cmd_host.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_host.sv
// Single-outstanding WISHBONE classic initiator: command stream in, response stream out,
// with bounded retry. Define WB_HOST_TIMEOUT_EN to add the unterminated-strobe timeout.
module wb_cmd_host #(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [DATA_WIDTH-1:0]   resp_dat_o,
  output logic [1:0]              resp_status_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  output logic [1:0]              dbg_state_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_GAP  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid, once raised, holds its payload stable until that edge.
  state_t                r_state, w_state;
  logic                  r_cmd_ready, w_cmd_ready;
  logic                  r_cyc, w_cyc;
  logic                  r_we, w_we;
  logic [ADDR_WIDTH-1:0] r_adr, w_adr;
  logic [DATA_WIDTH-1:0] r_dat, w_dat;
  logic [SW-1:0]         r_sel, w_sel;
  logic                  r_resp_valid, w_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_dat, w_resp_dat;
  logic [1:0]            r_resp_status, w_resp_status;
  logic [RW-1:0]         r_retry, w_retry;
  logic                  w_accept;
  logic                  w_expired;

`ifdef WB_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] r_tmo, w_tmo;

  // Counts BUS cycles without a termination; restarts on every new strobe.
  always_comb begin
    w_tmo = r_tmo;
    if (r_state == S_BUS) w_tmo = r_tmo + TW'(1);
    else                  w_tmo = '0;
  end

  assign w_expired = (r_state == S_BUS) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_tmo <= '0;
    else       r_tmo <= w_tmo;
  end
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_expired    = 1'b0;
`endif

  assign w_accept = cmd_valid_i && r_cmd_ready;

  always_comb begin
    w_state       = r_state;
    w_cmd_ready   = 1'b0;
    w_cyc         = 1'b0;
    w_we          = r_we;
    w_adr         = r_adr;
    w_dat         = r_dat;
    w_sel         = r_sel;
    w_resp_valid  = 1'b0;
    w_resp_dat    = r_resp_dat;
    w_resp_status = r_resp_status;
    w_retry       = r_retry;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (w_accept) begin
          w_state     = S_BUS;
          w_cmd_ready = 1'b0;
          w_cyc       = 1'b1;
          w_we        = cmd_we_i;
          w_adr       = cmd_adr_i;
          w_dat       = cmd_dat_i;
          w_sel       = cmd_sel_i;
          w_retry     = '0;
        end
      end
      S_BUS: begin
        w_cyc = 1'b1;
        if (wb_err_i) begin
          w_state       = S_RESP;
          w_cyc         = 1'b0;
          w_resp_valid  = 1'b1;
          w_resp_dat    = '0;
          w_resp_status = 2'b01;
        end else if (wb_rty_i) begin
          w_cyc = 1'b0;
          if (r_retry < RW'(MAX_RETRY)) begin
            w_state = S_GAP;
            w_retry = r_retry + RW'(1);
          end else begin
            w_state       = S_RESP;
            w_resp_valid  = 1'b1;
            w_resp_dat    = '0;
            w_resp_status = 2'b10;
          end
        end else if (wb_ack_i) begin
          w_state       = S_RESP;
          w_cyc         = 1'b0;
          w_resp_valid  = 1'b1;
          w_resp_dat    = r_we ? '0 : wb_dat_i;
          w_resp_status = 2'b00;
        end else if (w_expired) begin
          w_state       = S_RESP;
          w_cyc         = 1'b0;
          w_resp_valid  = 1'b1;
          w_resp_dat    = '0;
          w_resp_status = 2'b11;
        end
      end
      S_GAP: begin
        w_state = S_BUS;
        w_cyc   = 1'b1;
      end
      S_RESP: begin
        if (resp_ready_i) begin
          w_state     = S_IDLE;
          w_cmd_ready = 1'b1;
        end else begin
          w_resp_valid = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_cyc         <= 1'b0;
      r_we          <= 1'b0;
      r_adr         <= '0;
      r_dat         <= '0;
      r_sel         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_dat    <= '0;
      r_resp_status <= 2'b00;
      r_retry       <= '0;
    end else begin
      r_state       <= w_state;
      r_cmd_ready   <= w_cmd_ready;
      r_cyc         <= w_cyc;
      r_we          <= w_we;
      r_adr         <= w_adr;
      r_dat         <= w_dat;
      r_sel         <= w_sel;
      r_resp_valid  <= w_resp_valid;
      r_resp_dat    <= w_resp_dat;
      r_resp_status <= w_resp_status;
      r_retry       <= w_retry;
    end
  end

  assign cmd_ready_o   = r_cmd_ready;
  assign wb_cyc_o      = r_cyc;
  assign wb_stb_o      = r_cyc;
  assign wb_we_o       = r_we;
  assign wb_adr_o      = r_adr;
  assign wb_dat_o      = r_dat;
  assign wb_sel_o      = r_sel;
  assign resp_valid_o  = r_resp_valid;
  assign resp_dat_o    = r_resp_dat;
  assign resp_status_o = r_resp_status;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_wb_cmd_host.sv
// Bench for wb_cmd_host: behavioural WISHBONE target plus a response scoreboard.
module tb_wb_cmd_host;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MODE_ACK = 0, MODE_ERR = 1, MODE_RTY = 2, MODE_SILENT = 3, MODE_ERRACK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [SW-1:0] cmd_sel_i;
  logic          resp_valid_o, resp_ready_i;
  logic [DW-1:0] resp_dat_o;
  logic [1:0]    resp_status_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic [DW-1:0] tgt_data;
  logic          wb_ack_i, wb_err_i, wb_rty_i;
  logic [1:0]    dbg_state_o;

  wb_cmd_host #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(3), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_dat_o(resp_dat_o), .resp_status_o(resp_status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(tgt_data), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_edge = 0;
  logic [DW+1:0] exp_q[$];

  // Target model, updated on the falling edge so terminations are stable at the rising edge
  int            tgt_mode = MODE_ACK;
  int            tgt_waits = 0;
  int            wait_cnt = 0;
  int            stb_cycles = 0, we_dat_cycles = 0, seg_cnt = 0, low_run = 0, gap_bad = 0;
  logic          prev_stb = 1'b0;
  logic [AW-1:0] seen_adr = '0;
  logic          seen_we = 1'b0;
  logic [SW-1:0] seen_sel = '0;

  always @(negedge clk) begin
    if (rst) begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      wait_cnt = 0; prev_stb = 1'b0;
    end else if (wb_cyc_o && wb_stb_o) begin
      stb_cycles++;
      if (wb_we_o && wb_dat_o == 32'h1234_5678) we_dat_cycles++;
      if (!prev_stb) begin
        if (seg_cnt > 0 && low_run != 1) gap_bad++;
        seg_cnt++;
      end
      seen_adr = wb_adr_o; seen_we = wb_we_o; seen_sel = wb_sel_o;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (wait_cnt >= tgt_waits) begin
        case (tgt_mode)
          MODE_ACK:    wb_ack_i = 1'b1;
          MODE_ERR:    wb_err_i = 1'b1;
          MODE_RTY:    wb_rty_i = 1'b1;
          MODE_ERRACK: begin wb_err_i = 1'b1; wb_ack_i = 1'b1; end
          default:     ;
        endcase
      end
      wait_cnt++;
      prev_stb = 1'b1;
      low_run = 0;
    end else begin
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      wait_cnt = 0;
      prev_stb = 1'b0;
      low_run++;
    end
  end

  function automatic logic [DW+1:0] model(input int mode, input logic we, input logic [DW-1:0] rd);
    case (mode)
      MODE_ACK:    return {2'b00, (we ? 32'h0 : rd)};
      MODE_ERR:    return {2'b01, 32'h0};
      MODE_ERRACK: return {2'b01, 32'h0};
      MODE_RTY:    return {2'b10, 32'h0};
      default:     return {2'b11, 32'h0};
    endcase
  endfunction

  // Driver: present a command and wait for acceptance; pushes the expected response
  task automatic do_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [SW-1:0] sel);
    bit ok = 0;
    stb_cycles = 0; we_dat_cycles = 0; seg_cnt = 0; gap_bad = 0;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel; cmd_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready_o) begin ok = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready_o never high within 50 cycles (adr %h)", adr);
    end else begin
      acc_edge = cyc_n + 1;
      exp_q.push_back(model(tgt_mode, we, tgt_data));
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  // Wait for a response, compare it against the scoreboard; lat counts edges from accept inclusive
  task automatic wait_resp(input string name, output int lat);
    bit ok = 0;
    logic [DW+1:0] exp;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid_o) begin ok = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_resp_timeout: resp_valid_o never rose within 200 cycles", name);
      return;
    end
    lat = cyc_n - acc_edge + 1;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected: response %b/%h with empty queue", name, resp_status_o, resp_dat_o);
      return;
    end
    exp = exp_q.pop_front();
    if ({resp_status_o, resp_dat_o} !== exp) begin
      n_fail++;
      $display("FAIL %s_resp: got %b/%h expected %b/%h", name, resp_status_o, resp_dat_o,
               exp[DW+1:DW], exp[DW-1:0]);
    end
    if (resp_ready_i) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_resp_drop: resp_valid_o %b expected 0 after consume", name, resp_valid_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid_i = 1'b0; resp_ready_i = 1'b1;
    cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_sel_i = '0; tgt_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, resp_valid_o} !== 5'b0 ||
        wb_adr_o !== '0 || wb_dat_o !== '0 || wb_sel_o !== '0 ||
        resp_dat_o !== '0 || resp_status_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy %b cyc %b resp_valid %b adr %h expected all 0",
               cmd_ready_o, wb_cyc_o, resp_valid_o, wb_adr_o);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready_o %b expected 1 after first edge", cmd_ready_o);
    end
    n_checks++;
    if (dbg_state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: dbg_state_o %0d expected 0", dbg_state_o);
    end
  endtask

  task automatic test_read();
    int lat;
    tgt_mode = MODE_ACK; tgt_waits = 0; tgt_data = 32'hDEAD_BEEF;
    do_cmd(1'b0, 22'h000800, 32'h0, 4'hF);
    wait_resp("read0", lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL read0_latency: got %0d expected 2", lat); end
    n_checks++;
    if (stb_cycles !== 1) begin n_fail++; $display("FAIL read0_stb: got %0d expected 1", stb_cycles); end
    n_checks++;
    if (seen_adr !== 22'h000800 || seen_we !== 1'b0) begin
      n_fail++;
      $display("FAIL read0_bus: adr %h we %b expected 000800/0", seen_adr, seen_we);
    end
  endtask

  task automatic test_write();
    int lat;
    tgt_mode = MODE_ACK; tgt_waits = 3; tgt_data = 32'h5555_AAAA;
    do_cmd(1'b1, 22'h200004, 32'h1234_5678, 4'hF);
    wait_resp("write3", lat);
    n_checks++;
    if (we_dat_cycles !== 4) begin n_fail++; $display("FAIL write3_we_cycles: got %0d expected 4", we_dat_cycles); end
    n_checks++;
    if (stb_cycles !== 4) begin n_fail++; $display("FAIL write3_stb: got %0d expected 4", stb_cycles); end
    n_checks++;
    if (seen_adr !== 22'h200004 || seen_sel !== 4'hF) begin
      n_fail++;
      $display("FAIL write3_bus: adr %h sel %h expected 200004/f", seen_adr, seen_sel);
    end
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL write3_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_retry();
    int lat;
    tgt_mode = MODE_RTY; tgt_waits = 0; tgt_data = 32'h1111_2222;
    do_cmd(1'b0, 22'h00_0010, 32'h0, 4'h3);
    wait_resp("retry", lat);
    n_checks++;
    if (stb_cycles !== 4 || seg_cnt !== 4) begin
      n_fail++;
      $display("FAIL retry_strobes: cycles %0d segments %0d expected 4/4", stb_cycles, seg_cnt);
    end
    n_checks++;
    if (gap_bad !== 0) begin n_fail++; $display("FAIL retry_gap: %0d gaps not 1 cycle expected 0", gap_bad); end
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL retry_latency: got %0d expected 8", lat); end
  endtask

  task automatic test_err_ack();
    int lat;
    tgt_mode = MODE_ERRACK; tgt_waits = 0; tgt_data = 32'hCAFE_F00D;
    do_cmd(1'b0, 22'h000100, 32'h0, 4'hF);
    wait_resp("err_ack", lat);
    n_checks++;
    if (stb_cycles !== 1) begin n_fail++; $display("FAIL err_ack_stb: got %0d expected 1", stb_cycles); end
  endtask

  task automatic test_backpressure();
    logic [DW+1:0] exp;
    bit ok = 0;
    resp_ready_i = 1'b0;
    tgt_mode = MODE_ACK; tgt_waits = 1; tgt_data = 32'hA5A5_0001;
    do_cmd(1'b0, 22'h0000F0, 32'h0, 4'hF);
    exp = model(MODE_ACK, 1'b0, 32'hA5A5_0001);
    for (int i = 0; i < 50; i++) begin
      if (resp_valid_o) begin ok = 1; break; end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (!ok || resp_valid_o !== 1'b1 || {resp_status_o, resp_dat_o} !== exp || dbg_state_o !== 2'd3) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid %b resp %b/%h state %0d expected 1 00/a5a50001 3",
                 i, resp_valid_o, resp_status_o, resp_dat_o, dbg_state_o);
      end
      @(negedge clk);
    end
    resp_ready_i = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    n_checks++;
    if (resp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid %b ready %b expected 0/1", resp_valid_o, cmd_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int n = 0; n < 6; n++) begin
      tgt_mode  = ($urandom_range(0, 1) == 0) ? MODE_ACK : MODE_ERR;
      tgt_waits = $urandom_range(0, 2);
      tgt_data  = $urandom;
      do_cmd(1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom));
      wait_resp("b2b", lat);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, resp_valid_o} !== 5'b0 ||
        wb_adr_o !== '0 || wb_dat_o !== '0 || resp_dat_o !== '0 || resp_status_o !== 2'b00) begin
      n_fail++;
      $display("FAIL %s: rdy %b cyc %b we %b valid %b adr %h dat %h expected all 0",
               name, cmd_ready_o, wb_cyc_o, wb_we_o, resp_valid_o, wb_adr_o, resp_dat_o);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int stray = 0;
    tgt_mode = MODE_ACK; tgt_waits = 20; tgt_data = 32'h0F0F_0F0F;
    do_cmd(1'b1, 22'h3FFFFF, 32'hFFFF_FFFF, 4'hF);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_bus_async");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid_o) stray++;
      @(negedge clk);
    end
    tgt_mode = MODE_ACK; tgt_waits = 0; tgt_data = 32'h0BAD_F00D;
    do_cmd(1'b0, 22'h000404, 32'h0, 4'hF);
    wait_resp("after_rst_bus", lat);
    resp_ready_i = 1'b0;
    tgt_data = 32'h7777_8888;
    do_cmd(1'b0, 22'h000408, 32'h0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      if (resp_valid_o) break;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_resp_async");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    resp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid_o) stray++;
      @(negedge clk);
    end
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL rst_no_resp: %0d stray response cycles expected 0", stray); end
    tgt_data = 32'h1357_9BDF;
    do_cmd(1'b0, 22'h00040C, 32'h0, 4'hF);
    wait_resp("after_rst_resp", lat);
  endtask

`ifdef WB_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    tgt_mode = MODE_SILENT; tgt_waits = 0; tgt_data = 32'h2468_ACE0;
    do_cmd(1'b0, 22'h001000, 32'h0, 4'hF);
    wait_resp("timeout", lat);
    n_checks++;
    if (stb_cycles !== 16 || lat !== 17) begin
      n_fail++;
      $display("FAIL timeout_len: stb %0d lat %0d expected 16/17", stb_cycles, lat);
    end
    tgt_mode = MODE_ACK; tgt_waits = 15;
    do_cmd(1'b0, 22'h001004, 32'h0, 4'hF);
    wait_resp("ack_at_expiry", lat);
    n_checks++;
    if (stb_cycles !== 16) begin n_fail++; $display("FAIL ack_at_expiry_stb: got %0d expected 16", stb_cycles); end
  endtask
`endif

  initial begin
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_retry();
    test_err_ack();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_HOST_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
